// File: rtl/sound_event_scheduler.sv
// sound_event_scheduler
// Latches single-cycle game sound requests, arbitrates them by priority
// (goal > wall > hit) and issues one registered trigger pulse per sound.
// After each pulse it holds off further sounds for the tone duration and
// then a silence gap. A goal request preempts a playing hit or wall tone.
module sound_event_scheduler #(
    parameter int HIT_CYCLES  = 5_000_000,
    parameter int WALL_CYCLES = 5_000_000,
    parameter int GOAL_CYCLES = 25_000_000,
    parameter int GAP_CYCLES  = 1_000_000,
    parameter int CNT_W       = 25
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       hit_req,
    input  logic       wall_req,
    input  logic       goal_req,
    input  logic       mute,
    output logic       hit,
    output logic       wall,
    output logic       goal,
    output logic       busy,
    output logic [1:0] active,
    output logic [7:0] merged_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        GAP  = 2'd2
    } state_t;

    // Pending bit positions, also used to index the request vector.
    localparam int P_HIT  = 0;
    localparam int P_WALL = 1;
    localparam int P_GOAL = 2;

    localparam logic [1:0] ACT_NONE = 2'd0;
    localparam logic [1:0] ACT_HIT  = 2'd1;
    localparam logic [1:0] ACT_WALL = 2'd2;
    localparam logic [1:0] ACT_GOAL = 2'd3;

    localparam logic [CNT_W-1:0] HIT_LOAD  = CNT_W'(HIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] WALL_LOAD = CNT_W'(WALL_CYCLES - 1);
    localparam logic [CNT_W-1:0] GOAL_LOAD = CNT_W'(GOAL_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD  =
        (GAP_CYCLES > 0) ? CNT_W'(GAP_CYCLES - 1) : '0;
    localparam bit HAS_GAP = (GAP_CYCLES > 0);

    state_t           state, state_n;
    logic [2:0]       pend, pend_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [1:0]       active_n;
    logic             hit_n, wall_n, goal_n;
    logic [7:0]       merged_n;

    logic [2:0]       req;
    logic [2:0]       consume;
    logic             launch;
    logic [1:0]       merge_inc;
    logic [8:0]       merge_sum;

    assign req  = {goal_req, wall_req, hit_req};
    assign busy = (state != IDLE);

    // State, pending bits, counter and registered outputs.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // register samples the pre-edge values computed by the combinational block.
        if (rst) begin
            state      <= IDLE;
            pend       <= '0;
            cnt        <= '0;
            active     <= ACT_NONE;
            hit        <= 1'b0;
            wall       <= 1'b0;
            goal       <= 1'b0;
            merged_cnt <= '0;
        end else begin
            state      <= state_n;
            pend       <= pend_n;
            cnt        <= cnt_n;
            active     <= active_n;
            hit        <= hit_n;
            wall       <= wall_n;
            goal       <= goal_n;
            merged_cnt <= merged_n;
        end
    end

    // Next-state logic: arbitration, preemption, hold/gap timing, pending and merge tracking.
    always_comb begin
        // NOTE: every signal driven here gets a default first; a path that
        // leaves one unassigned would infer a latch.
        state_n   = state;
        pend_n    = pend;
        cnt_n     = cnt;
        active_n  = active;
        hit_n     = 1'b0;
        wall_n    = 1'b0;
        goal_n    = 1'b0;
        merged_n  = merged_cnt;
        consume   = '0;
        launch    = 1'b0;
        merge_inc = '0;
        merge_sum = '0;

        case (state)
            IDLE: begin
                launch = |pend;
            end
            HOLD: begin
                if (pend[P_GOAL] && (active != ACT_GOAL)) begin
                    // Interrupted hit/wall tone is dropped, not requeued.
                    consume[P_GOAL] = 1'b1;
                    goal_n          = 1'b1;
                    cnt_n           = GOAL_LOAD;
                    active_n        = ACT_GOAL;
                end else if (cnt == '0) begin
                    active_n = ACT_NONE;
                    if (HAS_GAP) begin
                        state_n = GAP;
                        cnt_n   = GAP_LOAD;
                    end else begin
                        // Without a gap, pass through IDLE so a 1-cycle tone
                        // can never produce back-to-back pulses on one output.
                        state_n = IDLE;
                    end
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            GAP: begin
                if (cnt == '0) begin
                    // The gap already separates pulses, so a pending sound
                    // launches on the same edge the gap expires.
                    state_n = IDLE;
                    launch  = |pend;
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            default: begin
                state_n  = IDLE;
                active_n = ACT_NONE;
            end
        endcase

        if (launch) begin
            state_n = HOLD;
            if (pend[P_GOAL]) begin
                consume[P_GOAL] = 1'b1;
                goal_n          = 1'b1;
                cnt_n           = GOAL_LOAD;
                active_n        = ACT_GOAL;
            end else if (pend[P_WALL]) begin
                consume[P_WALL] = 1'b1;
                wall_n          = 1'b1;
                cnt_n           = WALL_LOAD;
                active_n        = ACT_WALL;
            end else begin
                consume[P_HIT] = 1'b1;
                hit_n          = 1'b1;
                cnt_n          = HIT_LOAD;
                active_n       = ACT_HIT;
            end
        end

        // A request on a bit that stays pending is a merge; a request on the
        // edge that consumes its bit simply re-queues the event.
        for (int i = 0; i < 3; i++) begin
            if (req[i] && pend[i] && !consume[i]) begin
                merge_inc = merge_inc + 2'd1;
            end
            pend_n[i] = (pend[i] & ~consume[i]) | req[i];
        end
        merge_sum = {1'b0, merged_cnt} + 9'(merge_inc);
        merged_n  = merge_sum[8] ? 8'hFF : merge_sum[7:0];

        if (mute) begin
            state_n  = IDLE;
            pend_n   = '0;
            cnt_n    = '0;
            active_n = ACT_NONE;
            hit_n    = 1'b0;
            wall_n   = 1'b0;
            goal_n   = 1'b0;
            merged_n = merged_cnt;
        end
    end

endmodule

// File: tb/tb_sound_event_scheduler.sv
// tb_sound_event_scheduler
// Directed bench for sound_event_scheduler with HIT=4, WALL=6, GOAL=10, GAP=2.
// Cycle 0 of each scenario is the first cycle after reset is released; a
// request driven in cycle c is sampled on the edge that ends cycle c.
module tb_sound_event_scheduler;

    logic       clk;
    logic       rst;
    logic       hit_req;
    logic       wall_req;
    logic       goal_req;
    logic       mute;
    logic       hit;
    logic       wall;
    logic       goal;
    logic       busy;
    logic [1:0] active;
    logic [7:0] merged_cnt;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    logic       th [0:63];
    logic       tw [0:63];
    logic       tg [0:63];
    logic       tb [0:63];
    logic [1:0] ta [0:63];

    sound_event_scheduler #(
        .HIT_CYCLES (4),
        .WALL_CYCLES(6),
        .GOAL_CYCLES(10),
        .GAP_CYCLES (2),
        .CNT_W      (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .hit_req   (hit_req),
        .wall_req  (wall_req),
        .goal_req  (goal_req),
        .mute      (mute),
        .hit       (hit),
        .wall      (wall),
        .goal      (goal),
        .busy      (busy),
        .active    (active),
        .merged_cnt(merged_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic log_cycle();
        if (cyc < 64) begin
            th[cyc] = hit;
            tw[cyc] = wall;
            tg[cyc] = goal;
            tb[cyc] = busy;
            ta[cyc] = active;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        log_cycle();
    endtask

    task automatic goto(input int n);
        while (cyc < n) step();
    endtask

    task automatic start_scn();
        rst      = 1'b1;
        hit_req  = 1'b0;
        wall_req = 1'b0;
        goal_req = 1'b0;
        mute     = 1'b0;
        step();
        step();
        rst = 1'b0;
        cyc = 0;
        for (int i = 0; i < 64; i++) begin
            th[i] = 1'bx;
            tw[i] = 1'bx;
            tg[i] = 1'bx;
            tb[i] = 1'bx;
            ta[i] = 2'bxx;
        end
        log_cycle();
    endtask

    function automatic logic [63:0] at(input int n);
        return 64'd1 << n;
    endfunction

    // Compare every logged trigger against the expected pulse-cycle masks.
    task automatic check_pulses(input string name, input int lo, input int hi,
                                input logic [63:0] eh, input logic [63:0] ew,
                                input logic [63:0] eg);
        for (int c = lo; c <= hi; c++) begin
            check($sformatf("%s hit@%0d", name, c), 32'(th[c]), 32'(eh[c]));
            check($sformatf("%s wall@%0d", name, c), 32'(tw[c]), 32'(ew[c]));
            check($sformatf("%s goal@%0d", name, c), 32'(tg[c]), 32'(eg[c]));
        end
    endtask

    initial begin
        int pulses;
        int back_to_back;
        logic prev_hit;

        // ---- Scenario 1: reset state, then reset mid-HOLD with merge count set
        start_scn();
        check("rst hit", 32'(hit), 0);
        check("rst wall", 32'(wall), 0);
        check("rst goal", 32'(goal), 0);
        check("rst busy", 32'(busy), 0);
        check("rst active", 32'(active), 0);
        check("rst merged", 32'(merged_cnt), 0);
        goto(10); hit_req = 1'b1;
        step();   hit_req = 1'b0;
        goto(13); hit_req = 1'b1;
        step();   // cycle 14: hit still pending, second request merges
        step();   hit_req = 1'b0;
        check("s1 merged@15", 32'(merged_cnt), 1);
        check("s1 busy@15", 32'(busy), 1);
        goto(16); rst = 1'b1;
        step();
        check("s1 busy@17", 32'(busy), 0);
        check("s1 merged@17", 32'(merged_cnt), 0);
        step();   rst = 1'b0;
        check("s1 hit@18", 32'(hit), 0);
        check("s1 busy@18", 32'(busy), 0);
        check("s1 active@18", 32'(active), 0);
        check("s1 merged@18", 32'(merged_cnt), 0);
        goto(24);
        check("s1 busy@24", 32'(busy), 0);
        check_pulses("s1", 15, 24, 64'd0, 64'd0, 64'd0);

        // ---- Scenario 2: single hit, latency and occupancy
        start_scn();
        goto(10); hit_req = 1'b1;
        step();   hit_req = 1'b0;
        goto(22);
        check_pulses("s2", 10, 22, at(12), 64'd0, 64'd0);
        for (int c = 10; c <= 22; c++) begin
            check($sformatf("s2 active@%0d", c), 32'(ta[c]), (c >= 12 && c <= 15) ? 1 : 0);
            check($sformatf("s2 busy@%0d", c), 32'(tb[c]), (c >= 12 && c <= 17) ? 1 : 0);
        end

        // ---- Scenario 3: all three together, priority order goal > wall > hit
        start_scn();
        goto(10); hit_req = 1'b1; wall_req = 1'b1; goal_req = 1'b1;
        step();   hit_req = 1'b0; wall_req = 1'b0; goal_req = 1'b0;
        goto(45);
        check_pulses("s3", 10, 45, at(32), at(24), at(12));
        check("s3 active@12", 32'(ta[12]), 3);
        check("s3 active@21", 32'(ta[21]), 3);
        check("s3 active@22", 32'(ta[22]), 0);
        check("s3 active@24", 32'(ta[24]), 2);
        check("s3 active@29", 32'(ta[29]), 2);
        check("s3 active@30", 32'(ta[30]), 0);
        check("s3 active@32", 32'(ta[32]), 1);
        check("s3 active@35", 32'(ta[35]), 1);
        check("s3 busy@38", 32'(tb[38]), 0);

        // ---- Scenario 4: goal preempts a playing hit, hit is not replayed
        start_scn();
        goto(10); hit_req = 1'b1;
        step();   hit_req = 1'b0;
        goto(13); goal_req = 1'b1;
        step();   goal_req = 1'b0;
        goto(40);
        check_pulses("s4", 10, 40, at(12), 64'd0, at(15));
        check("s4 active@14", 32'(ta[14]), 1);
        for (int c = 15; c <= 25; c++) begin
            check($sformatf("s4 active@%0d", c), 32'(ta[c]), (c <= 24) ? 3 : 0);
        end
        check("s4 busy@27", 32'(tb[27]), 0);

        // ---- Scenario 5: re-queue during HOLD, merge while pending
        start_scn();
        goto(10); hit_req = 1'b1;
        step();   hit_req = 1'b0;
        goto(14); hit_req = 1'b1;
        step();   hit_req = 1'b0;
        goto(20); hit_req = 1'b1;
        step();   // cycle 21: still requesting, bit already pending
        step();   hit_req = 1'b0;
        check("s5 merged@22", 32'(merged_cnt), 1);
        goto(40);
        check_pulses("s5", 10, 40, at(12) | at(18) | at(24), 64'd0, 64'd0);
        check("s5 merged@40", 32'(merged_cnt), 1);

        // ---- Scenario 6: mute discards activity, then operation resumes
        start_scn();
        goto(10); goal_req = 1'b1;
        step();   goal_req = 1'b0;
        goto(14); mute = 1'b1;
        step();   hit_req = 1'b1;
        step();   hit_req = 1'b0;
        step();   mute = 1'b0;
        goto(20); hit_req = 1'b1;
        step();   hit_req = 1'b0;
        goto(32);
        check_pulses("s6", 10, 32, at(22), 64'd0, at(12));
        for (int c = 10; c <= 32; c++) begin
            check($sformatf("s6 busy@%0d", c), 32'(tb[c]),
                  ((c >= 12 && c <= 14) || (c >= 22 && c <= 27)) ? 1 : 0);
        end
        check("s6 active@15", 32'(ta[15]), 0);
        check("s6 merged@32", 32'(merged_cnt), 0);

        // ---- Scenario 7: continuous hit requests saturate merged_cnt
        start_scn();
        hit_req      = 1'b1;
        pulses       = 0;
        back_to_back = 0;
        prev_hit     = 1'b0;
        repeat (400) begin
            step();
            if (hit) pulses++;
            if (hit && prev_hit) back_to_back++;
            prev_hit = hit;
        end
        hit_req = 1'b0;
        check("s7 pulses", 32'(pulses), 67);
        check("s7 back_to_back", 32'(back_to_back), 0);
        check("s7 merged sat", 32'(merged_cnt), 255);
        mute = 1'b1;
        step();
        step();
        mute = 1'b0;
        check("s7 mute busy", 32'(busy), 0);
        check("s7 mute merged hold", 32'(merged_cnt), 255);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
